// File: rtl/dual_wb_regfile_if.sv
// Writeback/register-file bus: both MEM/WB slots in, four decode read ports out.
// master = pipeline/decode side, slave = dual_wb_regfile.
interface dual_wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 8
);
  logic [PC_W-1:0]   pcPlus_WB_i1;
  logic [DATA_W-1:0] MemReadDataWB_i1;
  logic [DATA_W-1:0] AluResultWB_i1;
  logic [ADDR_W-1:0] dest_reg_WB_i1;
  logic [1:0]        MemtoRegWB_i1;
  logic              RegWriteEn_WB_i1;

  logic [PC_W-1:0]   pcPlus_WB_i2;
  logic [DATA_W-1:0] MemReadDataWB_i2;
  logic [DATA_W-1:0] AluResultWB_i2;
  logic [ADDR_W-1:0] dest_reg_WB_i2;
  logic [1:0]        MemtoRegWB_i2;
  logic              RegWriteEn_WB_i2;

  logic [ADDR_W-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [DATA_W-1:0] rd_data0, rd_data1, rd_data2, rd_data3;
  logic [DATA_W-1:0] wb_data_i1, wb_data_i2;
  logic              wb_conflict;

  modport master (
    output pcPlus_WB_i1, MemReadDataWB_i1, AluResultWB_i1, dest_reg_WB_i1,
           MemtoRegWB_i1, RegWriteEn_WB_i1,
           pcPlus_WB_i2, MemReadDataWB_i2, AluResultWB_i2, dest_reg_WB_i2,
           MemtoRegWB_i2, RegWriteEn_WB_i2,
           rd_addr0, rd_addr1, rd_addr2, rd_addr3,
    input  rd_data0, rd_data1, rd_data2, rd_data3,
           wb_data_i1, wb_data_i2, wb_conflict
  );

  modport slave (
    input  pcPlus_WB_i1, MemReadDataWB_i1, AluResultWB_i1, dest_reg_WB_i1,
           MemtoRegWB_i1, RegWriteEn_WB_i1,
           pcPlus_WB_i2, MemReadDataWB_i2, AluResultWB_i2, dest_reg_WB_i2,
           MemtoRegWB_i2, RegWriteEn_WB_i2,
           rd_addr0, rd_addr1, rd_addr2, rd_addr3,
    output rd_data0, rd_data1, rd_data2, rd_data3,
           wb_data_i1, wb_data_i2, wb_conflict
  );
endinterface

// File: rtl/dual_wb_regfile.sv
// Dual-issue writeback stage and 32-entry architectural register file with
// four write-through-bypassed read ports; slot 2 is younger and wins collisions.
module dual_wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  dual_wb_regfile_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_LINK = 2'b10,
    SEL_RSVD = 2'b11
  } wb_sel_e;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wb1, wb2;
  logic              wr1, wr2;
  logic [ADDR_W-1:0] ra [4];
  logic [DATA_W-1:0] rd [4];
  logic              conflict_q;

  function automatic logic [DATA_W-1:0] wb_select(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem,
    input logic [PC_W-1:0]   pc
  );
    case (wb_sel_e'(sel))
      SEL_ALU:  return alu;
      SEL_MEM:  return mem;
      SEL_LINK: return DATA_W'(pc);
      default:  return '0;
    endcase
  endfunction

  assign wb1 = wb_select(bus.MemtoRegWB_i1, bus.AluResultWB_i1,
                         bus.MemReadDataWB_i1, bus.pcPlus_WB_i1);
  assign wb2 = wb_select(bus.MemtoRegWB_i2, bus.AluResultWB_i2,
                         bus.MemReadDataWB_i2, bus.pcPlus_WB_i2);

  // Register 0 is never written, so an enabled write to it is a no-op.
  assign wr1 = bus.RegWriteEn_WB_i1 && (bus.dest_reg_WB_i1 != '0);
  assign wr2 = bus.RegWriteEn_WB_i2 && (bus.dest_reg_WB_i2 != '0);

  // NOTE: the whole array is cleared on reset because software may read any
  // register before writing it; this forces flops rather than an SRAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      conflict_q <= 1'b0;
    end else begin
      // NOTE: with non-blocking assignments the last write to the same entry
      // in this block wins, so slot 2 is placed after slot 1 on purpose.
      if (wr1) regs[bus.dest_reg_WB_i1] <= wb1;
      if (wr2) regs[bus.dest_reg_WB_i2] <= wb2;
      conflict_q <= wr1 && wr2 && (bus.dest_reg_WB_i1 == bus.dest_reg_WB_i2);
    end
  end

  assign ra[0] = bus.rd_addr0;
  assign ra[1] = bus.rd_addr1;
  assign ra[2] = bus.rd_addr2;
  assign ra[3] = bus.rd_addr3;

  // NOTE: every branch below assigns rd[p] after a default, so no latch forms.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd[p] = regs[ra[p]];
      if (ra[p] == '0)                              rd[p] = '0;
      else if (wr2 && (bus.dest_reg_WB_i2 == ra[p])) rd[p] = wb2;
      else if (wr1 && (bus.dest_reg_WB_i1 == ra[p])) rd[p] = wb1;
    end
  end

  assign bus.rd_data0    = rd[0];
  assign bus.rd_data1    = rd[1];
  assign bus.rd_data2    = rd[2];
  assign bus.rd_data3    = rd[3];
  assign bus.wb_data_i1  = wb1;
  assign bus.wb_data_i2  = wb2;
  assign bus.wb_conflict = conflict_q;
endmodule

// File: tb/tb_dual_wb_regfile.sv
// Directed vectors for dual_wb_regfile: select, commit, bypass priority,
// register 0, collisions and reset-during-write.
module tb_dual_wb_regfile;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PC_W   = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dual_wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) bus ();

  dual_wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  sel1, sel2;
    logic        en1, en2;
    logic [4:0]  d1, d2;
    logic [31:0] alu1, mem1, alu2, mem2;
    logic [7:0]  pc1, pc2;
    logic [4:0]  ra0, ra1, ra2, ra3;
    logic [31:0] e_wb1, e_wb2;
    logic [31:0] e_rd0, e_rd1, e_rd2, e_rd3;
    logic        e_conf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.pcPlus_WB_i1 = '0; bus.MemReadDataWB_i1 = '0; bus.AluResultWB_i1 = '0;
    bus.dest_reg_WB_i1 = '0; bus.MemtoRegWB_i1 = 2'b00; bus.RegWriteEn_WB_i1 = 1'b0;
    bus.pcPlus_WB_i2 = '0; bus.MemReadDataWB_i2 = '0; bus.AluResultWB_i2 = '0;
    bus.dest_reg_WB_i2 = '0; bus.MemtoRegWB_i2 = 2'b00; bus.RegWriteEn_WB_i2 = 1'b0;
    bus.rd_addr0 = '0; bus.rd_addr1 = '0; bus.rd_addr2 = '0; bus.rd_addr3 = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.MemtoRegWB_i1 = v.sel1; bus.RegWriteEn_WB_i1 = v.en1; bus.dest_reg_WB_i1 = v.d1;
    bus.AluResultWB_i1 = v.alu1; bus.MemReadDataWB_i1 = v.mem1; bus.pcPlus_WB_i1 = v.pc1;
    bus.MemtoRegWB_i2 = v.sel2; bus.RegWriteEn_WB_i2 = v.en2; bus.dest_reg_WB_i2 = v.d2;
    bus.AluResultWB_i2 = v.alu2; bus.MemReadDataWB_i2 = v.mem2; bus.pcPlus_WB_i2 = v.pc2;
    bus.rd_addr0 = v.ra0; bus.rd_addr1 = v.ra1; bus.rd_addr2 = v.ra2; bus.rd_addr3 = v.ra3;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    check($sformatf("v%0d wb_data_i1", i), bus.wb_data_i1, v.e_wb1);
    check($sformatf("v%0d wb_data_i2", i), bus.wb_data_i2, v.e_wb2);
    check($sformatf("v%0d rd_data0", i), bus.rd_data0, v.e_rd0);
    check($sformatf("v%0d rd_data1", i), bus.rd_data1, v.e_rd1);
    check($sformatf("v%0d rd_data2", i), bus.rd_data2, v.e_rd2);
    check($sformatf("v%0d rd_data3", i), bus.rd_data3, v.e_rd3);
    check($sformatf("v%0d wb_conflict", i), {31'b0, bus.wb_conflict}, {31'b0, v.e_conf});
  endtask

  // Shorthand: one vector with explicit fields, expected values hand-computed.
  function automatic vec_t mk(
    input logic [1:0] sel1, input logic en1, input logic [4:0] d1,
    input logic [31:0] alu1, input logic [31:0] mem1, input logic [7:0] pc1,
    input logic [1:0] sel2, input logic en2, input logic [4:0] d2,
    input logic [31:0] alu2, input logic [31:0] mem2, input logic [7:0] pc2,
    input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] ra3,
    input logic [31:0] e_wb1, input logic [31:0] e_wb2,
    input logic [31:0] e_rd0, input logic [31:0] e_rd1,
    input logic [31:0] e_rd2, input logic [31:0] e_rd3, input logic e_conf);
    vec_t v;
    v.sel1 = sel1; v.en1 = en1; v.d1 = d1; v.alu1 = alu1; v.mem1 = mem1; v.pc1 = pc1;
    v.sel2 = sel2; v.en2 = en2; v.d2 = d2; v.alu2 = alu2; v.mem2 = mem2; v.pc2 = pc2;
    v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2; v.ra3 = ra3;
    v.e_wb1 = e_wb1; v.e_wb2 = e_wb2;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_rd3 = e_rd3;
    v.e_conf = e_conf;
    return v;
  endfunction

  vec_t vecs [$];

  initial begin
    // Each vector is driven on the falling edge, checked 1 ns later (before
    // the commit edge); wb_conflict reflects the previous vector's writes.
    //          s1  en d1  alu1          mem1          pc1    s2  en d2  alu2          mem2          pc2    reads           wb1           wb2           rd0           rd1           rd2           rd3          conf
    vecs.push_back(mk(2'b00,0, 0, 32'h0,        32'h0,        8'h00, 2'b00,0, 0, 32'h0,        32'h0,        8'h00, 5,6,7,8,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,       0));
    vecs.push_back(mk(2'b00,1, 3, 32'h1234,     32'h777,      8'h11, 2'b01,1, 4, 32'h999,      32'hDEADBEEF, 8'h22, 3,4,0,1,  32'h1234,     32'hDEADBEEF, 32'h1234,     32'hDEADBEEF, 32'h0,        32'h0,       0));
    vecs.push_back(mk(2'b00,0, 0, 32'h0,        32'h0,        8'h00, 2'b00,0, 0, 32'h0,        32'h0,        8'h00, 3,4,9,31, 32'h0,        32'h0,        32'h1234,     32'hDEADBEEF, 32'h0,        32'h0,       0));
    vecs.push_back(mk(2'b00,1, 9, 32'h11,       32'h0,        8'h00, 2'b00,1, 9, 32'h22,       32'h0,        8'h00, 9,9,3,4,  32'h11,       32'h22,       32'h22,       32'h22,       32'h1234,     32'hDEADBEEF,0));
    vecs.push_back(mk(2'b00,0, 0, 32'h0,        32'h0,        8'h00, 2'b00,0, 0, 32'h0,        32'h0,        8'h00, 9,0,0,0,  32'h0,        32'h0,        32'h22,       32'h0,        32'h0,        32'h0,       1));
    vecs.push_back(mk(2'b00,0, 0, 32'h0,        32'h0,        8'h00, 2'b00,0, 0, 32'h0,        32'h0,        8'h00, 0,9,0,0,  32'h0,        32'h0,        32'h0,        32'h22,       32'h0,        32'h0,       0));
    vecs.push_back(mk(2'b11,0, 2, 32'hABCD,     32'h1,        8'h33, 2'b10,1, 31,32'h5555,     32'h6666,     8'hA4, 31,2,31,0, 32'h0,        32'hA4,       32'hA4,       32'h0,        32'hA4,       32'h0,       0));
    vecs.push_back(mk(2'b00,1, 0, 32'hFFFF,     32'h0,        8'h00, 2'b00,1, 5, 32'h77,       32'h0,        8'h00, 0,31,5,5, 32'hFFFF,     32'h77,       32'h0,        32'hA4,       32'h77,       32'h77,      0));
    vecs.push_back(mk(2'b00,0, 0, 32'h0,        32'h0,        8'h00, 2'b11,1, 5, 32'h88,       32'h99,       8'h44, 5,0,31,9, 32'h0,        32'h0,        32'h0,        32'h0,        32'hA4,       32'h22,      0));
    vecs.push_back(mk(2'b00,0, 0, 32'h0,        32'h0,        8'h00, 2'b00,0, 0, 32'h0,        32'h0,        8'h00, 5,0,3,4,  32'h0,        32'h0,        32'h0,        32'h0,        32'h1234,     32'hDEADBEEF,0));
    vecs.push_back(mk(2'b00,1, 0, 32'h1,        32'h0,        8'h00, 2'b00,1, 0, 32'h2,        32'h0,        8'h00, 0,0,0,0,  32'h1,        32'h2,        32'h0,        32'h0,        32'h0,        32'h0,       0));
    vecs.push_back(mk(2'b01,1, 12,32'h5,        32'hC1,       8'h00, 2'b00,0, 12,32'hC2,       32'h0,        8'h00, 12,12,0,9, 32'hC1,       32'hC2,       32'hC1,       32'hC1,       32'h0,        32'h22,      0));
    vecs.push_back(mk(2'b00,0, 0, 32'h0,        32'h0,        8'h00, 2'b00,0, 0, 32'h0,        32'h0,        8'h00, 12,5,31,0, 32'h0,        32'h0,        32'hC1,       32'h0,        32'hA4,       32'h0,       0));
    // Slot 1 writes 7, slot 2 writes 6: sets up the reset sequence below.
    vecs.push_back(mk(2'b00,1, 7, 32'h55,       32'h0,        8'h00, 2'b00,1, 6, 32'h66,       32'h0,        8'h00, 7,6,0,0,  32'h55,       32'h66,       32'h55,       32'h66,       32'h0,        32'h0,       0));

    drive_idle();
    bus.rd_addr0 = 5; bus.rd_addr1 = 6; bus.rd_addr2 = 7; bus.rd_addr3 = 8;
    reset = 1'b0;
    #12;
    check("reset rd_data0", bus.rd_data0, 32'h0);
    check("reset wb_conflict", {31'b0, bus.wb_conflict}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // Stored values after the last commit, then a collision on 7 to arm
    // wb_conflict before reset is dropped between edges.
    @(negedge clk);
    drive_idle();
    bus.rd_addr0 = 7; bus.rd_addr1 = 6;
    #1;
    check("stored r7", bus.rd_data0, 32'h55);
    check("stored r6", bus.rd_data1, 32'h66);
    bus.RegWriteEn_WB_i1 = 1'b1; bus.dest_reg_WB_i1 = 7; bus.AluResultWB_i1 = 32'h55;
    bus.RegWriteEn_WB_i2 = 1'b1; bus.dest_reg_WB_i2 = 7; bus.AluResultWB_i2 = 32'h55;
    @(negedge clk);
    drive_idle();
    bus.rd_addr0 = 7;
    #1;
    check("pre-reset conflict", {31'b0, bus.wb_conflict}, 32'h1);
    check("pre-reset r7", bus.rd_data0, 32'h55);
    #1;
    reset = 1'b0;
    #1;
    check("async reset r7", bus.rd_data0, 32'h0);
    check("async reset conflict", {31'b0, bus.wb_conflict}, 32'h0);

    // Enabled write across an edge while reset is held: must commit nothing.
    bus.RegWriteEn_WB_i1 = 1'b1; bus.dest_reg_WB_i1 = 7; bus.AluResultWB_i1 = 32'h99;
    @(posedge clk);
    #1;
    drive_idle();
    bus.rd_addr0 = 7;
    #1;
    check("reset-held edge r7", bus.rd_data0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("after release r7", bus.rd_data0, 32'h0);
    check("after release conflict", {31'b0, bus.wb_conflict}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_wb_regfile.md
Name: dual_wb_regfile

Overview:
- Consumer end of both MEM/WB pipeline registers in the dual-issue core: the writeback stage plus the architectural register file.
- Selects the writeback value for inst1 and for inst2 (ALU result, memory read data, or link PC).
- Commits both values to a 32-entry register file in the same cycle.
- Serves four read ports to decode (rs/rt for each issue slot) with write-through bypass.

Parameters:
- DATA_W, 32, register and writeback data width
- ADDR_W, 5, register index width (2**ADDR_W entries)
- PC_W, 8, width of the pcPlus link value

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pcPlus_WB_i1  in  PC_W  link value, slot 1
- MemReadDataWB_i1  in  DATA_W  load data, slot 1
- AluResultWB_i1  in  DATA_W  ALU result, slot 1
- dest_reg_WB_i1  in  ADDR_W  destination, slot 1
- MemtoRegWB_i1  in  2  writeback select, slot 1
- RegWriteEn_WB_i1  in  1  write enable, slot 1
- pcPlus_WB_i2, MemReadDataWB_i2, AluResultWB_i2, dest_reg_WB_i2, MemtoRegWB_i2, RegWriteEn_WB_i2  in  same widths  slot 2 (younger) equivalents
- rd_addr0..rd_addr3  in  ADDR_W each  read addresses (0/1 = slot1 rs/rt, 2/3 = slot2 rs/rt)
- rd_data0..rd_data3  out  DATA_W each  read data
- wb_data_i1  out  DATA_W  selected writeback value, slot 1 (to forwarding unit)
- wb_data_i2  out  DATA_W  selected writeback value, slot 2
- wb_conflict  out  1  registered flag: previous cycle had both slots writing the same non-zero register

Behaviour:
- Reset (async, reset=0):
  - all entries cleared to 0
  - wb_conflict cleared to 0
  - rd_data*/wb_data* are combinational and reflect cleared state immediately
- Writeback select, per slot, combinational:
  - 00 -> AluResult
  - 01 -> MemReadData
  - 10 -> pcPlus zero-extended to DATA_W
  - 11 -> reserved, value 0; write still occurs if enabled
- Commit:
  - On rising clk, slot k writes wb_data_ik to entry dest_reg_WB_ik when RegWriteEn_WB_ik=1 and dest != 0.
- Register 0:
  - hardwired zero; writes ignored; reads always return 0, including via bypass
- Same-destination collision:
  - Both slots enabled with equal non-zero dest -> slot 2 value is stored (program order).
  - wb_conflict=1 the following cycle; 0 otherwise.
- Read ports, combinational, write-through bypass, priority order:
  1. addr=0 -> 0
  2. slot2 writing same addr this cycle -> wb_data_i2
  3. slot1 writing same addr this cycle -> wb_data_i1
  4. otherwise the stored entry
- Latency:
  - read 0 cycles
  - written value visible in storage one edge later, and via bypass in the same cycle
- Reset asserted mid-write: reset wins; that edge commits nothing.
- No stall input: WB always commits. Bubbles arrive as RegWriteEn=0.

Test Plan:
- Reset then read all four ports at addr 5,6,7,8 -> all return 0; wb_conflict=0.
- Slot1: MemtoReg=00, Alu=0x1234, dest=3, en=1. Slot2: MemtoReg=01, Mem=0xDEADBEEF, dest=4, en=1. After the edge, read 3 -> 0x00001234 and read 4 -> 0xDEADBEEF.
- Both slots write dest=9 (slot1 Alu=0x11, slot2 Alu=0x22). In the same cycle, rd_addr0=9 -> 0x22. After the edge, read 9 -> 0x22 and wb_conflict=1; next idle cycle wb_conflict=0.
- Slot2 MemtoReg=10, pcPlus=0xA4, dest=31 -> wb_data_i2=0x000000A4; entry 31 = 0xA4 after the edge.
- Slot1 writes dest=0 with Alu=0xFFFF -> read 0 returns 0 in the same cycle and afterwards.
- Entry 7 = 0x55 stored. Drop reset low between edges -> rd_data for addr 7 reads 0 immediately. An edge with en=1 while reset=0 leaves entry 7 = 0.
